// File: rtl/m_ext_pkg.sv
// Shared types and helpers for the M-extension multiply control path.
package m_ext_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } m_funct3_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4,
        DRAIN = 3'd5
    } mul_ctrl_state_t;

    // Returns {a_signed, b_signed}; MUL counts as signed/signed so its cached
    // product is reusable by a later MULH on the same operands.
    function automatic logic [1:0] mul_signedness(input logic [2:0] f3);
        logic [1:0] sgn;
        case (m_funct3_t'(f3))
            MUL, MULH: sgn = 2'b11;
            MULHSU:    sgn = 2'b10;
            default:   sgn = 2'b00;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// EX-side request/response and multiplier-side launch/capture signals.
interface mul_ctrl_if #(
    parameter int XLEN = 32
);
    logic                mul_start;
    logic [2:0]          mul_funct3;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic                flush;
    logic [XLEN-1:0]     mul_result;
    logic                mul_done;
    logic                mult_load;
    logic [XLEN-1:0]     mult_a;
    logic [XLEN-1:0]     mult_b;
    logic [2*XLEN-1:0]   mult_product;
    logic                mult_resp;

    modport slave (
        input  mul_start, mul_funct3, rs1_data, rs2_data, flush,
        input  mult_product, mult_resp,
        output mul_result, mul_done, mult_load, mult_a, mult_b
    );

    modport master (
        output mul_start, mul_funct3, rs1_data, rs2_data, flush,
        output mult_product, mult_resp,
        input  mul_result, mul_done, mult_load, mult_a, mult_b
    );
endinterface

// File: rtl/mul_result_cache.sv
// One-entry cache of the last signed-corrected 64-bit product and its key.
module mul_result_cache #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [XLEN-1:0]   wr_rs1,
    input  logic [XLEN-1:0]   wr_rs2,
    input  logic              wr_a_signed,
    input  logic              wr_b_signed,
    input  logic [2*XLEN-1:0] wr_prod,
    input  logic [XLEN-1:0]   rd_rs1,
    input  logic [XLEN-1:0]   rd_rs2,
    input  logic              rd_is_mul,
    input  logic              rd_a_signed,
    input  logic              rd_b_signed,
    output logic              hit,
    output logic [2*XLEN-1:0] rd_prod
);
    logic              valid_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic              a_signed_q;
    logic              b_signed_q;
    logic [2*XLEN-1:0] prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            a_signed_q <= 1'b0;
            b_signed_q <= 1'b0;
            prod_q     <= '0;
        end else if (we) begin
            valid_q    <= 1'b1;
            rs1_q      <= wr_rs1;
            rs2_q      <= wr_rs2;
            a_signed_q <= wr_a_signed;
            b_signed_q <= wr_b_signed;
            prod_q     <= wr_prod;
        end
    end

    // The low half is sign-independent, so MUL hits regardless of stored signedness.
    assign hit = valid_q && (rd_rs1 == rs1_q) && (rd_rs2 == rs2_q) &&
                 (rd_is_mul || ({rd_a_signed, rd_b_signed} == {a_signed_q, b_signed_q}));
    assign rd_prod = prod_q;

endmodule

// File: rtl/mul_ctrl.sv
// Sign handling, launch/capture sequencing and result selection around the
// shift/add multiplier, with a one-entry product cache.
module mul_ctrl
    import m_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    mul_ctrl_if.slave   bus
);
    mul_ctrl_state_t   state_q, state_d;
    m_funct3_t         funct3_q, funct3_d;
    logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
    logic              a_signed_q, a_signed_d, b_signed_q, b_signed_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] cap_q, cap_d, prod_q, prod_d;

    logic [1:0]        sgn;
    logic              neg_a, neg_b;
    logic              cache_we, cache_hit;
    logic [2*XLEN-1:0] cache_prod;
    logic              load_c, done_c;

    assign sgn   = mul_signedness(bus.mul_funct3);
    assign neg_a = sgn[1] & bus.rs1_data[XLEN-1];
    assign neg_b = sgn[0] & bus.rs2_data[XLEN-1];

    mul_result_cache #(.XLEN(XLEN)) u_cache (
        .clk         (clk),
        .rst         (rst),
        .we          (cache_we),
        .wr_rs1      (rs1_q),
        .wr_rs2      (rs2_q),
        .wr_a_signed (a_signed_q),
        .wr_b_signed (b_signed_q),
        .wr_prod     (prod_d),
        .rd_rs1      (bus.rs1_data),
        .rd_rs2      (bus.rs2_data),
        .rd_is_mul   (bus.mul_funct3 == MUL),
        .rd_a_signed (sgn[1]),
        .rd_b_signed (sgn[0]),
        .hit         (cache_hit),
        .rd_prod     (cache_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            funct3_q   <= MUL;
            rs1_q      <= '0;
            rs2_q      <= '0;
            a_signed_q <= 1'b0;
            b_signed_q <= 1'b0;
            neg_q      <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            cap_q      <= '0;
            prod_q     <= '0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            a_signed_q <= a_signed_d;
            b_signed_q <= b_signed_d;
            neg_q      <= neg_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            cap_q      <= cap_d;
            prod_q     <= prod_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        a_signed_d = a_signed_q;
        b_signed_d = b_signed_q;
        neg_d      = neg_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        cap_d      = cap_q;
        prod_d     = prod_q;
        cache_we   = 1'b0;
        load_c     = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mul_start && !bus.mul_funct3[2] && !bus.flush) begin
                    funct3_d   = m_funct3_t'(bus.mul_funct3);
                    rs1_d      = bus.rs1_data;
                    rs2_d      = bus.rs2_data;
                    a_signed_d = sgn[1];
                    b_signed_d = sgn[0];
                    neg_d      = neg_a ^ neg_b;
                    mag_a_d    = neg_a ? -bus.rs1_data : bus.rs1_data;
                    mag_b_d    = neg_b ? -bus.rs2_data : bus.rs2_data;
                    if (cache_hit) begin
                        prod_d  = cache_prod;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                load_c  = 1'b1;
                state_d = bus.flush ? DRAIN : WAIT;
            end
            WAIT: begin
                // The product is only present in the resp cycle, so grab it now.
                if (bus.mult_resp) begin
                    cap_d   = bus.mult_product;
                    state_d = bus.flush ? IDLE : FIX;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            FIX: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d   = neg_q ? -cap_q : cap_q;
                    cache_we = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            DRAIN: begin
                if (bus.mult_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mult_load  = load_c;
    assign bus.mul_done   = done_c;
    assign bus.mult_a     = mag_a_q;
    assign bus.mult_b     = mag_b_q;
    assign bus.mul_result = !done_c ? '0 :
                            (funct3_q == MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural multiplier and a result scoreboard.
module tb_mul_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   start_cyc = 0;
    int   op_id = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    mul_ctrl_if #(.XLEN(32)) bus();
    mul_ctrl #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: latency grows with min(a,b), capped at 30; product valid one cycle.
    logic        mb_busy = 1'b0;
    int          mb_cnt = 0;
    logic [31:0] mb_a = '0, mb_b = '0;
    always @(posedge clk) begin
        if (rst) begin
            mb_busy <= 1'b0;
            mb_cnt <= 0;
            bus.mult_resp <= 1'b0;
            bus.mult_product <= '0;
        end else begin
            bus.mult_resp <= 1'b0;
            bus.mult_product <= '0;
            if (bus.mult_load) begin
                logic [31:0] k;
                k = (bus.mult_a < bus.mult_b) ? bus.mult_a : bus.mult_b;
                if (k > 30) k = 30;
                mb_a <= bus.mult_a;
                mb_b <= bus.mult_b;
                if (k == 0) begin
                    bus.mult_resp <= 1'b1;
                    bus.mult_product <= {32'b0, bus.mult_a} * {32'b0, bus.mult_b};
                end else begin
                    mb_busy <= 1'b1;
                    mb_cnt <= int'(k) - 1;
                end
            end else if (mb_busy) begin
                if (mb_cnt == 0) begin
                    bus.mult_resp <= 1'b1;
                    bus.mult_product <= {32'b0, mb_a} * {32'b0, mb_b};
                    mb_busy <= 1'b0;
                end else begin
                    mb_cnt <= mb_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected response.
    logic prev_load = 1'b0;
    always @(negedge clk) begin
        if (!rst && bus.mult_load) check("load_single_cycle", {63'b0, prev_load}, 64'd0);
        prev_load = bus.mult_load;
        if (!rst && bus.mul_done) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h with no request outstanding", bus.mul_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("[TB] op %0d result=%h exp=%h latency=%0d", op_id, bus.mul_result, e.res, cyc - start_cyc);
                check("result", {32'b0, bus.mul_result}, {32'b0, e.res});
                if (e.lat > 0) check("latency", 64'(cyc - start_cyc), 64'(e.lat));
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input int lat, input bit expect_done);
        @(negedge clk);
        bus.mul_funct3 = f3;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.mul_start = 1'b1;
        start_cyc = cyc;
        op_id++;
        if (expect_done) sb_q.push_back('{res: er, lat: lat});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.mul_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mul_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no mul_done within 200 cycles, required a pulse");
        end
        bus.mul_start = 1'b0;
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int lat);
        issue(f3, a, b, er, lat, 1'b1);
        @(negedge clk);
        wait_done();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},   {63'b0, bus.mul_done}, 64'd0);
        check({tag, "_result"}, {32'b0, bus.mul_result}, 64'd0);
        check({tag, "_load"},   {63'b0, bus.mult_load}, 64'd0);
        check({tag, "_a"},      {32'b0, bus.mult_a}, 64'd0);
        check({tag, "_b"},      {32'b0, bus.mult_b}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.mul_start = 1'b0;
        bus.mul_funct3 = 3'b000;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // MULH -2 x 3: magnitudes 2 and 3 presented with a single load pulse.
        issue(3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 6, 1'b1);
        @(negedge clk);
        check("load_pulse", {63'b0, bus.mult_load}, 64'd1);
        check("mag_a", {32'b0, bus.mult_a}, 64'd2);
        check("mag_b", {32'b0, bus.mult_b}, 64'd3);
        wait_done();

        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        run(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 5);
        run(3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 5);
        run(3'b000, 32'd0, 32'd5, 32'd0, 4);
        run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);

        // Flush mid-multiply: no completion, operands held until the multiplier drains.
        issue(3'b000, 32'd1000, 32'd1000, 32'd0, 0, 1'b0);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        bus.mul_start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        begin
            int n = 0;
            while (!bus.mult_resp && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("drain_resp_seen", {63'b0, bus.mult_resp}, 64'd1);
            check("drain_hold_a", {32'b0, bus.mult_a}, 64'd1000);
        end
        run(3'b000, 32'd3, 32'd4, 32'd12, 7);
        run(3'b000, 32'd7, 32'd9, 32'd63, 11);
        run(3'b001, 32'd7, 32'd9, 32'd0, 1);

        // Reset during WAIT: outputs clear and the cache is invalidated.
        issue(3'b000, 32'd100, 32'd100, 32'd0, 0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        bus.mul_start = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;

        // funct3[2]=1 is never accepted.
        issue(3'b100, 32'd5, 32'd5, 32'd0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("div_no_load", {63'b0, bus.mult_load}, 64'd0);
        end
        bus.mul_start = 1'b0;

        run(3'b000, 32'd7, 32'd9, 32'd63, 11);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
